// File: rtl/fi_pkg.sv
// Shared types and constants for the fault-injection controller slice.
package fi_pkg;

    // Controller phases: waiting for a descriptor, counting the start delay,
    // driving the saboteurs, and the one-cycle completion report.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        INJECT = 2'd2,
        DONE   = 2'd3
    } fi_state_t;

    // Fault types understood by the super saboteurs (passed through unchanged).
    localparam logic [1:0] FI_SA0  = 2'b00;
    localparam logic [1:0] FI_SA1  = 2'b01;
    localparam logic [1:0] FI_FLIP = 2'b10;

    // Default width of the delay / duration counters.
    localparam int FI_CNT_W = 16;

endpackage

// File: rtl/fi_down_counter.sv
// Loadable down-counter with a zero flag. It stops at zero instead of
// wrapping, so an expired window stays expired until the next load.
module fi_down_counter
    import fi_pkg::*;
#(
    parameter int CNT_W = FI_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/sabouter_fault_ctrl.sv
// Single-fault injection controller: takes one descriptor, waits the start
// delay, drives the selected super saboteur for the requested window, then
// reports completion with a one-cycle done (plus err for a bad index).
module sabouter_fault_ctrl
    import fi_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N_SAB = 8,
    parameter int CNT_W = FI_CNT_W,
    parameter int IDX_W = (N_SAB > 1) ? $clog2(N_SAB) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [IDX_W-1:0] i_cfg_sab_idx,
    input  logic [WIDTH-1:0] i_cfg_bit_mask,
    input  logic [1:0]       i_cfg_ctrl,
    input  logic [CNT_W-1:0] i_cfg_delay,
    input  logic [CNT_W-1:0] i_cfg_duration,
    input  logic             i_abort,
    output logic [N_SAB-1:0] o_en_super_sabouter,
    output logic [WIDTH-1:0] o_en_basic_sabouter,
    output logic [1:0]       o_ctrl,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    // Extra bit so an index equal to N_SAB is representable in the compare.
    localparam int              N_SAB_I = N_SAB;
    localparam logic [IDX_W:0]  N_SAB_W = N_SAB_I[IDX_W:0];

    // The counter holds "cycles remaining minus one", so a window of length
    // v is loaded as v-1; zero maps to zero (duration 0 never uses the count).
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    fi_state_t state_reg, state_next;

    logic [IDX_W-1:0] idx_reg,  idx_next;
    logic [WIDTH-1:0] mask_reg, mask_next;
    logic [1:0]       ctrl_reg, ctrl_next;
    logic [CNT_W-1:0] dur_reg,  dur_next;
    logic             err_reg,  err_next;

    logic [N_SAB-1:0] en_super_reg, en_super_next;
    logic [WIDTH-1:0] en_basic_reg, en_basic_next;
    logic [1:0]       ctrl_out_reg, ctrl_out_next;
    logic             done_reg,     done_next;
    logic             err_out_reg,  err_out_next;

    logic [N_SAB-1:0] onehot_next;
    logic             accept;
    logic             idx_bad;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    assign accept  = i_cfg_valid && (state_reg == IDLE);
    assign idx_bad = ({1'b0, i_cfg_sab_idx} >= N_SAB_W);

    // Delay and duration share one counter; it is reloaded on entry to ARM
    // (with the delay) and on entry to INJECT (with the duration).
    fi_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // Counter reload: at accept pick delay (ARM) or duration (straight to
    // INJECT); at the ARM->INJECT hand-over load the latched duration.
    always_comb begin
        cnt_load     = accept || ((state_reg == ARM) && (state_next == INJECT));
        cnt_load_val = sat_dec(dur_reg);
        if (state_reg == IDLE) begin
            cnt_load_val = (i_cfg_delay != '0) ? sat_dec(i_cfg_delay)
                                               : sat_dec(i_cfg_duration);
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort wins over the natural end of the window.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_cfg_valid) begin
                    if (idx_bad) begin
                        state_next = DONE;
                    end else if (i_cfg_delay == '0) begin
                        state_next = INJECT;
                    end else begin
                        state_next = ARM;
                    end
                end
            end
            ARM: begin
                if (i_abort) begin
                    state_next = DONE;
                end else if (cnt_zero) begin
                    state_next = INJECT;
                end
            end
            INJECT: begin
                if (i_abort) begin
                    state_next = DONE;
                end else if ((dur_reg != '0) && cnt_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Descriptor fields are captured only at accept and held afterwards.
    always_comb begin
        idx_next  = idx_reg;
        mask_next = mask_reg;
        ctrl_next = ctrl_reg;
        dur_next  = dur_reg;
        err_next  = err_reg;
        if (accept) begin
            idx_next  = i_cfg_sab_idx;
            mask_next = i_cfg_bit_mask;
            ctrl_next = i_cfg_ctrl;
            dur_next  = i_cfg_duration;
            err_next  = idx_bad;
        end
    end

    // Descriptor holding registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idx_reg  <= '0;
            mask_reg <= '0;
            ctrl_reg <= '0;
            dur_reg  <= '0;
            err_reg  <= 1'b0;
        end else begin
            idx_reg  <= idx_next;
            mask_reg <= mask_next;
            ctrl_reg <= ctrl_next;
            dur_reg  <= dur_next;
            err_reg  <= err_next;
        end
    end

    // One-hot decode of the (next) saboteur index.
    generate
        for (genvar gi = 0; gi < N_SAB; gi++) begin : g_onehot
            assign onehot_next[gi] = (idx_next == IDX_W'(gi));
        end
    endgenerate

    // Output decode from the upcoming state, so the registered outputs line
    // up with the state they describe.
    always_comb begin
        en_super_next = '0;
        en_basic_next = '0;
        ctrl_out_next = '0;
        done_next     = 1'b0;
        err_out_next  = 1'b0;
        if (state_next == INJECT) begin
            en_super_next = onehot_next;
            en_basic_next = mask_next;
            ctrl_out_next = ctrl_next;
        end
        if (state_next == DONE) begin
            done_next    = 1'b1;
            err_out_next = err_next;
        end
    end

    // Output registers; reset drops every enable immediately and issues no done.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            en_super_reg <= '0;
            en_basic_reg <= '0;
            ctrl_out_reg <= '0;
            done_reg     <= 1'b0;
            err_out_reg  <= 1'b0;
        end else begin
            en_super_reg <= en_super_next;
            en_basic_reg <= en_basic_next;
            ctrl_out_reg <= ctrl_out_next;
            done_reg     <= done_next;
            err_out_reg  <= err_out_next;
        end
    end

    assign o_cfg_ready         = (state_reg == IDLE);
    assign o_busy              = (state_reg == ARM) || (state_reg == INJECT);
    assign o_en_super_sabouter = en_super_reg;
    assign o_en_basic_sabouter = en_basic_reg;
    assign o_ctrl              = ctrl_out_reg;
    assign o_done              = done_reg;
    assign o_err               = err_out_reg;

endmodule
